lsu_axi_master: RTL and testbench

- Parametrised AXI4 load/store unit: successor to the single-beat, word-only LSU.
- Sits between EXU and the AXI4 crossbar; one outstanding transaction at a time.
- Adds sub-word access (byte/half/word/dword), lane steering and sign extension, and misalignment trapping.
- Adds concurrent AW/W issue, and a decoupled response channel with error codes.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_axi_master_if.sv | 58 +++++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/lsu_axi_master.sv | 192 +++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the AXI4 load/store unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUS      = 2'd2,
        ERR_ID       = 2'd3
    } err_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // An access must sit on its natural boundary; dword needs a 64-bit core.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input logic       dword_ok);
        logic [2:0] mask;
        case (size)
            SZ_B:    mask = 3'b000;
            SZ_H:    mask = 3'b001;
            SZ_W:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return ((addr_lo & mask) != 3'b000) || ((size == SZ_D) && !dword_ok);
    endfunction

    // A bus error outranks an ID mismatch.
    function automatic err_e resp_to_err(input logic [1:0] resp, input logic id_ok);
        if (resp != RESP_OKAY) return ERR_BUS;
        if (!id_ok)            return ERR_ID;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4 single-beat channel bundle between the LSU and the crossbar.
// Latency: none, wires only.
// Backpressure: standard AXI valid/ready on every channel.
interface lsu_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32,
    parameter int ID_W   = 4
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic               wvalid;
    logic               wready;
    logic [BUS_W-1:0]   wdata;
    logic [BUS_W/8-1:0] wstrb;
    logic               wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic             rvalid;
    logic             rready;
    logic [BUS_W-1:0] rdata;
    logic [1:0]       rresp;
    logic [ID_W-1:0]  rid;
    logic             rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, bid, output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input  rvalid, rdata, rresp, rid, rlast, output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, bid, input bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rid, rlast, input rready
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extract + extend.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align #(
    parameter  int XLEN  = 32,
    parameter  int BUS_W = 32,
    localparam int NB    = BUS_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [OFF_W-1:0] st_off,
    input  logic [1:0]       st_size,
    input  logic [XLEN-1:0]  st_wdata,
    output logic [BUS_W-1:0] st_data,
    output logic [NB-1:0]    st_strb,
    input  logic [OFF_W-1:0] ld_off,
    input  logic [1:0]       ld_size,
    input  logic             ld_unsigned,
    input  logic [BUS_W-1:0] ld_rdata,
    output logic [XLEN-1:0]  ld_data
);
    int               st_bytes;
    int               ld_bits;
    logic             ld_sign;
    logic [BUS_W-1:0] ld_shift;

    assign st_data  = BUS_W'(st_wdata) << {st_off, 3'b000};
    assign ld_shift = ld_rdata >> {ld_off, 3'b000};

    // Enable the contiguous run of byte lanes covered by the store.
    always_comb begin
        st_bytes = 1 << st_size;
        st_strb  = '0;
        for (int i = 0; i < NB; i++) begin
            st_strb[i] = (i >= int'(st_off)) && (i < int'(st_off) + st_bytes);
        end
    end

    // Keep the access-sized low bits, fill the rest with zero or the sign bit.
    always_comb begin
        ld_bits = 8 << ld_size;
        ld_sign = 1'b0;
        ld_data = '0;
        for (int i = 0; i < BUS_W; i++) begin
            if (i == ld_bits - 1) ld_sign = ld_shift[i];
        end
        for (int i = 0; i < XLEN; i++) begin
            ld_data[i] = (i < ld_bits) ? ld_shift[i] : (ld_unsigned ? 1'b0 : ld_sign);
        end
    end
endmodule

// File: rtl/lsu_axi_master.sv
// AXI4 load/store unit: one outstanding single-beat access, sub-word lanes, error codes.
// Latency: accept T0, address phase T1, data/resp beat T2, resp_valid T3 at zero wait.
// Backpressure: req_ready only in IDLE; response held until resp_ready; AXI valids held to handshake.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int BUS_W  = 32,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    lsu_axi_master_if.master  axi
);
    localparam int NB    = BUS_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [BUS_W-1:0]  wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              aw_done, w_done;
    logic [XLEN-1:0]   rdata_q;
    err_e              err_q;

    logic              accept, misaligned, aw_fire, w_fire;
    logic              issue_aw, issue_w, issue_ar, take_b, take_r, resp_pend, idle_rdy;
    logic [BUS_W-1:0]  st_data;
    logic [NB-1:0]     st_strb;
    logic [XLEN-1:0]   ld_data;
    logic              unused_rlast;

    lsu_lane_align #(.XLEN(XLEN), .BUS_W(BUS_W)) u_align (
        .st_off      (req_addr[OFF_W-1:0]),
        .st_size     (req_size),
        .st_wdata    (req_wdata),
        .st_data     (st_data),
        .st_strb     (st_strb),
        .ld_off      (addr_q[OFF_W-1:0]),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_rdata    (axi.rdata),
        .ld_data     (ld_data)
    );

    assign misaligned   = is_misaligned(req_addr[2:0], req_size, XLEN == 64);
    assign accept       = req_valid && idle_rdy;
    assign aw_fire      = issue_aw && axi.awready;
    assign w_fire       = issue_w && axi.wready;
    assign unused_rlast = axi.rlast;

    assign req_ready   = idle_rdy;
    assign resp_valid  = resp_pend;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign axi.awvalid = issue_aw;
    assign axi.wvalid  = issue_w;
    assign axi.bready  = take_b;
    assign axi.arvalid = issue_ar;
    assign axi.rready  = take_r;

    assign axi.awaddr  = addr_q;
    assign axi.awid    = id_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = BURST_INCR;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.araddr  = addr_q;
    assign axi.arid    = id_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = BURST_INCR;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs; all handshakes are forced low while in reset.
    always_comb begin
        state_d   = state_q;
        idle_rdy  = 1'b0;
        issue_aw  = 1'b0;
        issue_w   = 1'b0;
        take_b    = 1'b0;
        issue_ar  = 1'b0;
        take_r    = 1'b0;
        resp_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_rdy = 1'b1;
                if (req_valid) begin
                    if (misaligned)   state_d = ST_RESP;
                    else if (req_wen) state_d = ST_WR_REQ;
                    else              state_d = ST_RD_ADDR;
                end
            end
            ST_WR_REQ: begin
                issue_aw = !aw_done;
                issue_w  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                take_b = 1'b1;
                if (axi.bvalid) state_d = ST_RESP;
            end
            ST_RD_ADDR: begin
                issue_ar = 1'b1;
                if (axi.arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                take_r = 1'b1;
                if (axi.rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_pend = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            idle_rdy  = 1'b0;
            issue_aw  = 1'b0;
            issue_w   = 1'b0;
            take_b    = 1'b0;
            issue_ar  = 1'b0;
            take_r    = 1'b0;
            resp_pend = 1'b0;
        end
    end

    // Request capture, per-channel write progress, and response data/error.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    id_q    <= id_q + 1'b1;
                    addr_q  <= req_addr;
                    size_q  <= req_size;
                    uns_q   <= req_unsigned;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= misaligned ? ERR_MISALIGN : ERR_OK;
                    if (req_wen) begin
                        wdata_q <= st_data;
                        wstrb_q <= st_strb;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                ST_WR_RESP: if (axi.bvalid) err_q <= resp_to_err(axi.bresp, axi.bid == id_q);
                ST_RD_DATA: if (axi.rvalid) begin
                    rdata_q <= ld_data;
                    err_q   <= resp_to_err(axi.rresp, axi.rid == id_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master driving a scripted single-beat AXI slave.
// Latency: checks T1/T2/T3 phase timing at zero wait.
// Backpressure: exercises delayed AW/W/AR readies and a held-off resp_ready.
module tb_lsu_axi_master;
    localparam int ADDR_W = 32, XLEN = 32, BUS_W = 32, ID_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_rd_q[$];
    logic [1:0]  exp_err_q[$];
    logic [3:0]  exp_id = 4'd0;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_uns;

    always #5 clock = ~clock;

    lsu_axi_master_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .ID_W(ID_W)) axi ();

    lsu_axi_master #(.ADDR_W(ADDR_W), .XLEN(XLEN), .BUS_W(BUS_W), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi(axi)
    );

    function automatic logic [31:0] load_model(logic [31:0] rd, logic [1:0] off, logic [1:0] sz, logic uns);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (sz)
            2'd0:    return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'd1:    return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    task automatic issue(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        bit mis;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL issue_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = addr; req_wen = wen; req_size = size; req_unsigned = uns; req_wdata = wdata;
        cur_addr = addr; cur_size = size; cur_uns = uns; cur_wdata = wdata;
        exp_id = exp_id + 4'd1;
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        if (mis) begin exp_rd_q.push_back(32'h0); exp_err_q.push_back(2'd1); end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic write_phase(input int aw_dly, input int w_dly, input logic [1:0] bresp_v, input bit bad_id);
        int aw_cnt, w_cnt, c;
        bit aw_hs, w_hs;
        logic [31:0] e_wd;
        logic [3:0]  e_st;
        aw_cnt = 0; w_cnt = 0; c = 0; aw_hs = 0; w_hs = 0;
        e_wd = cur_wdata << (8 * cur_addr[1:0]);
        case (cur_size)
            2'd0:    e_st = 4'b0001 << cur_addr[1:0];
            2'd1:    e_st = 4'b0011 << cur_addr[1:0];
            default: e_st = 4'b1111;
        endcase
        while (!(aw_hs && w_hs) && c < 20) begin
            axi.awready = (c >= aw_dly);
            axi.wready  = (c >= w_dly);
            vectors++; if (axi.bready !== 1'b0) begin miscompares++; $display("FAIL bready_early: got %b want 0 (cycle %0d)", axi.bready, c); end
            if (c == 0) begin
                vectors++; if (axi.awaddr !== cur_addr) begin miscompares++; $display("FAIL awaddr: got %h want %h", axi.awaddr, cur_addr); end
                vectors++; if (axi.awid !== exp_id) begin miscompares++; $display("FAIL awid: got %h want %h", axi.awid, exp_id); end
                vectors++; if (axi.awsize !== {1'b0, cur_size}) begin miscompares++; $display("FAIL awsize: got %h want %h", axi.awsize, {1'b0, cur_size}); end
                vectors++; if (axi.wdata !== e_wd) begin miscompares++; $display("FAIL wdata: got %h want %h", axi.wdata, e_wd); end
                vectors++; if (axi.wstrb !== e_st) begin miscompares++; $display("FAIL wstrb: got %b want %b", axi.wstrb, e_st); end
            end
            vectors++; if (axi.awvalid !== !aw_hs) begin miscompares++; $display("FAIL awvalid_level: got %b want %b (cycle %0d)", axi.awvalid, !aw_hs, c); end
            vectors++; if (axi.wvalid !== !w_hs) begin miscompares++; $display("FAIL wvalid_level: got %b want %b (cycle %0d)", axi.wvalid, !w_hs, c); end
            if (axi.awvalid === 1'b1) aw_cnt++;
            if (axi.wvalid === 1'b1) w_cnt++;
            if (axi.awvalid === 1'b1 && axi.awready) aw_hs = 1;
            if (axi.wvalid === 1'b1 && axi.wready) w_hs = 1;
            c++;
            @(negedge clock);
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        vectors++; if (!(aw_hs && w_hs)) begin miscompares++; $display("FAIL aw_w_timeout: aw %b w %b want both 1", aw_hs, w_hs); end
        vectors++; if (aw_cnt != aw_dly + 1) begin miscompares++; $display("FAIL awvalid_cycles: got %0d want %0d", aw_cnt, aw_dly + 1); end
        vectors++; if (w_cnt != w_dly + 1) begin miscompares++; $display("FAIL wvalid_cycles: got %0d want %0d", w_cnt, w_dly + 1); end
        vectors++; if (axi.bready !== 1'b1) begin miscompares++; $display("FAIL bready: got %b want 1", axi.bready); end
        axi.bvalid = 1'b1; axi.bresp = bresp_v; axi.bid = bad_id ? (exp_id ^ 4'd1) : exp_id;
        exp_rd_q.push_back(32'h0);
        exp_err_q.push_back(bresp_v != 2'b00 ? 2'd2 : (bad_id ? 2'd3 : 2'd0));
        @(negedge clock);
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    task automatic read_phase(input int ar_dly, input logic [31:0] rd, input logic [1:0] rresp_v,
                              input bit bad_id, input bit do_r);
        int c;
        bit hs;
        c = 0; hs = 0;
        while (!hs && c < 20) begin
            axi.arready = (c >= ar_dly);
            vectors++; if (axi.arvalid !== 1'b1 || axi.rready !== 1'b0) begin miscompares++; $display("FAIL ar_phase: arvalid %b rready %b want 1 0 (cycle %0d)", axi.arvalid, axi.rready, c); end
            if (c == 0) begin
                vectors++; if (axi.araddr !== cur_addr) begin miscompares++; $display("FAIL araddr: got %h want %h", axi.araddr, cur_addr); end
                vectors++; if (axi.arid !== exp_id) begin miscompares++; $display("FAIL arid: got %h want %h", axi.arid, exp_id); end
                vectors++; if (axi.arsize !== {1'b0, cur_size}) begin miscompares++; $display("FAIL arsize: got %h want %h", axi.arsize, {1'b0, cur_size}); end
            end
            if (axi.arvalid === 1'b1 && axi.arready) hs = 1;
            c++;
            @(negedge clock);
        end
        axi.arready = 1'b0;
        vectors++; if (!hs) begin miscompares++; $display("FAIL ar_timeout: got no handshake want one"); end
        if (do_r) begin
            vectors++; if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0) begin miscompares++; $display("FAIL r_phase: rready %b arvalid %b want 1 0", axi.rready, axi.arvalid); end
            axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = rresp_v; axi.rlast = 1'b1;
            axi.rid = bad_id ? (exp_id ^ 4'd1) : exp_id;
            exp_rd_q.push_back(load_model(rd, cur_addr[1:0], cur_size, cur_uns));
            exp_err_q.push_back(rresp_v != 2'b00 ? 2'd2 : (bad_id ? 2'd3 : 2'd0));
            @(negedge clock);
            axi.rvalid = 1'b0; axi.rresp = 2'b00;
        end
    endtask

    task automatic resp_phase(input int hold);
        int w;
        logic [31:0] e_rd;
        logic [1:0]  e_err;
        w = 0;
        while (resp_valid !== 1'b1 && w < 5) begin @(negedge clock); w++; end
        vectors++; if (w != 0) begin miscompares++; $display("FAIL resp_latency: got %0d extra cycles want 0", w); end
        e_rd = 32'hx; e_err = 2'bx;
        vectors++;
        if (exp_rd_q.size() == 0) begin miscompares++; $display("FAIL scoreboard_empty: got 0 entries want 1"); end
        else begin e_rd = exp_rd_q.pop_front(); e_err = exp_err_q.pop_front(); end
        for (int h = 0; h <= hold; h++) begin
            vectors++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin miscompares++; $display("FAIL resp_hold: valid %b req_ready %b want 1 0 (cycle %0d)", resp_valid, req_ready, h); end
            vectors++; if (resp_rdata !== e_rd) begin miscompares++; $display("FAIL resp_rdata: got %h want %h", resp_rdata, e_rd); end
            vectors++; if (resp_err !== e_err) begin miscompares++; $display("FAIL resp_err: got %0d want %0d", resp_err, e_err); end
            if (h < hold) @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL resp_release: valid %b req_ready %b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++; if ({req_ready, resp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 7'b0) begin
            miscompares++; $display("FAIL %s_handshakes: got %b want 0000000", tag,
                {req_ready, resp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); end
        vectors++; if (resp_rdata !== 32'h0 || resp_err !== 2'd0) begin miscompares++; $display("FAIL %s_resp: rdata %h err %0d want 0 0", tag, resp_rdata, resp_err); end
        vectors++; if (axi.awaddr !== 32'h0 || axi.araddr !== 32'h0 || axi.wdata !== 32'h0 || axi.wstrb !== 4'h0) begin
            miscompares++; $display("FAIL %s_addr_data: awaddr %h araddr %h wdata %h wstrb %h want 0", tag, axi.awaddr, axi.araddr, axi.wdata, axi.wstrb); end
        vectors++; if (axi.awid !== 4'd0 || axi.arid !== 4'd0) begin miscompares++; $display("FAIL %s_id: awid %h arid %h want 0", tag, axi.awid, axi.arid); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        vectors++; if (axi.awlen !== 8'd0 || axi.arlen !== 8'd0 || axi.awburst !== 2'b01 || axi.arburst !== 2'b01 || axi.wlast !== 1'b1) begin
            miscompares++; $display("FAIL const_fields: awlen %h arlen %h awburst %b arburst %b wlast %b want 0 0 01 01 1",
                axi.awlen, axi.arlen, axi.awburst, axi.arburst, axi.wlast); end
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_store_byte();
        issue(32'h8000_0003, 1'b1, 2'd0, 1'b0, 32'h0000_00A5);
        write_phase(0, 0, 2'b00, 0);
        resp_phase(0);
    endtask

    task automatic test_loads();
        issue(32'h1000_0002, 1'b0, 2'd0, 1'b0, 32'h0); read_phase(0, 32'h0080_0000, 2'b00, 0, 1); resp_phase(0);
        issue(32'h1000_0002, 1'b0, 2'd0, 1'b1, 32'h0); read_phase(0, 32'h0080_0000, 2'b00, 0, 1); resp_phase(0);
        issue(32'h1000_0002, 1'b0, 2'd1, 1'b0, 32'h0); read_phase(2, 32'h8001_0000, 2'b00, 0, 1); resp_phase(0);
        issue(32'h1000_0000, 1'b0, 2'd1, 1'b1, 32'h0); read_phase(0, 32'h1234_F00D, 2'b00, 0, 1); resp_phase(0);
        issue(32'h1000_0004, 1'b0, 2'd2, 1'b0, 32'h0); read_phase(0, 32'hDEAD_BEEF, 2'b00, 0, 1); resp_phase(0);
        issue(32'h1000_0001, 1'b0, 2'd0, 1'b0, 32'h0); read_phase(0, 32'h0000_7F00, 2'b00, 0, 1); resp_phase(0);
    endtask

    task automatic test_misalign();
        issue(32'h1000_0002, 1'b0, 2'd2, 1'b0, 32'h0);
        vectors++; if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
            miscompares++; $display("FAIL mis_no_bus: arvalid %b awvalid %b wvalid %b want 0", axi.arvalid, axi.awvalid, axi.wvalid); end
        resp_phase(0);
        issue(32'h1000_0001, 1'b1, 2'd1, 1'b0, 32'h1234); resp_phase(0);
        issue(32'h1000_0008, 1'b0, 2'd3, 1'b0, 32'h0); resp_phase(0);
        issue(32'h1000_0004, 1'b0, 2'd2, 1'b0, 32'h0); read_phase(0, 32'h0BAD_CAFE, 2'b00, 0, 1); resp_phase(0);
    endtask

    task automatic test_aw_w_indep();
        issue(32'h4000_0008, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D); write_phase(3, 0, 2'b00, 0); resp_phase(0);
        issue(32'h4000_0006, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF); write_phase(0, 2, 2'b00, 0); resp_phase(0);
        issue(32'h4000_0005, 1'b1, 2'd0, 1'b0, 32'h0000_005A); write_phase(2, 2, 2'b00, 0); resp_phase(0);
    endtask

    task automatic test_errors();
        issue(32'h5000_0000, 1'b1, 2'd2, 1'b0, 32'h1111_2222); write_phase(0, 0, 2'b10, 0); resp_phase(0);
        issue(32'h5000_0004, 1'b0, 2'd2, 1'b0, 32'h0); read_phase(0, 32'h3333_4444, 2'b00, 1, 1); resp_phase(0);
        issue(32'h5000_0008, 1'b1, 2'd2, 1'b0, 32'h5555_6666); write_phase(0, 0, 2'b10, 1); resp_phase(0);
        issue(32'h5000_0003, 1'b0, 2'd0, 1'b0, 32'h0); read_phase(0, 32'hF000_0000, 2'b11, 0, 1); resp_phase(0);
    endtask

    task automatic test_backpressure();
        issue(32'h6000_0002, 1'b0, 2'd1, 1'b1, 32'h0); read_phase(0, 32'hA5A5_0000, 2'b00, 0, 1); resp_phase(5);
    endtask

    task automatic test_reset_mid();
        issue(32'h7000_0000, 1'b0, 2'd2, 1'b0, 32'h0);
        read_phase(0, 32'h0, 2'b00, 0, 0);
        vectors++; if (axi.rready !== 1'b1) begin miscompares++; $display("FAIL rd_data_state: rready %b want 1", axi.rready); end
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        exp_id = 4'd0;
        exp_rd_q.delete(); exp_err_q.delete();
        @(negedge clock);
        issue(32'h7000_0010, 1'b0, 2'd2, 1'b0, 32'h0); read_phase(0, 32'h7777_8888, 2'b00, 0, 1); resp_phase(0);
    endtask

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rid = '0; axi.rlast = 1'b0;
        test_reset();
        test_store_byte();
        test_loads();
        test_misalign();
        test_aw_w_indep();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
